// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the radix-4 sequential multiplier.
// The optional early-termination build is selected by MUL_EARLY_TERM_EN.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIG_ZERO  = 2'd0,
    DIG_ONE   = 2'd1,
    DIG_TWO   = 2'd2,
    DIG_THREE = 2'd3
  } digit_t;

  localparam int DEF_SIZE = 16;
  localparam int STEP_W   = $clog2(DEF_SIZE / 2);

  // Step-counter width for an arbitrary operand width (SIZE even, >= 4).
  function automatic int step_width(input int size);
    return $clog2(size / 2);
  endfunction

endpackage

// File: rtl/mul_radix4_sequencer_if.sv
// Start/operand/result bundle between a requester and mul_radix4_sequencer.
// Used identically in both builds (MUL_EARLY_TERM_EN defined or not).
interface mul_radix4_sequencer_if #(
  parameter int SIZE = 16
);
  logic              iStart;
  logic [SIZE-1:0]   iA;
  logic [SIZE-1:0]   iB;
  logic              oBusy;
  logic              oDone;
  logic [2*SIZE-1:0] oResult;

  modport master (output iStart, iA, iB, input oBusy, oDone, oResult);
  modport slave  (input iStart, iA, iB, output oBusy, oDone, oResult);
endinterface

// File: rtl/mul_digit_mux.sv
// Combinational radix-4 digit multiple: 0, A, 2A or 3A, truncated to W bits.
// Shared by both builds (MUL_EARLY_TERM_EN defined or not).
module mul_digit_mux
  import mul_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   digit_i,
  input  logic [W-1:0] a_i,
  output logic [W-1:0] mult_o
);

  always_comb begin
    mult_o = '0;
    case (digit_t'(digit_i))
      DIG_ZERO:  mult_o = '0;
      DIG_ONE:   mult_o = a_i;
      DIG_TWO:   mult_o = a_i << 1;
      DIG_THREE: mult_o = (a_i << 1) + a_i;
      default:   mult_o = '0;
    endcase
  end

endmodule

// File: rtl/mul_radix4_sequencer.sv
// Radix-4 sequential multiplier: one 2-bit digit of B per RUN cycle.
// Define MUL_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier is zero.
module mul_radix4_sequencer
  import mul_seq_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  mul_radix4_sequencer_if.slave bus
);

  localparam int SW = step_width(SIZE);
  localparam logic [SW-1:0] LAST_STEP = SW'(SIZE / 2 - 1);

  state_t            state_q, state_d;
  logic [2*SIZE-1:0] a_q, a_d;
  logic [SIZE-1:0]   b_q, b_d;
  logic [2*SIZE-1:0] acc_q, acc_d;
  logic [SW-1:0]     step_q, step_d;
  logic [2*SIZE-1:0] result_q, result_d;
  logic [2*SIZE-1:0] mult;
  logic              last;

  mul_digit_mux #(.W(2 * SIZE)) u_digit_mux (
    .digit_i (b_q[1:0]),
    .a_i     (a_q),
    .mult_o  (mult)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      step_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    step_d   = step_q;
    result_d = result_q;
    last     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          a_d     = {{SIZE{1'b0}}, bus.iA};
          b_d     = bus.iB;
          acc_d   = '0;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = acc_q + mult;
        a_d    = a_q << 2;
        b_d    = b_q >> 2;
        step_d = step_q + 1'b1;
`ifdef MUL_EARLY_TERM_EN
        last   = (step_q == LAST_STEP) || (b_d == '0);
`else
        last   = (step_q == LAST_STEP);
`endif
        // Result is captured on the way into DONE so it is valid with oDone.
        if (last) begin
          result_d = acc_d;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.oBusy   = (state_q != IDLE);
  assign bus.oDone   = (state_q == DONE);
  assign bus.oResult = result_q;

endmodule

// File: tb/tb_mul_radix4_sequencer.sv
// Self-checking bench for mul_radix4_sequencer (SIZE=16); honours MUL_EARLY_TERM_EN.
// Reference: plain integer product and latency from the most significant set bit of B.
module tb_mul_radix4_sequencer;

  localparam int SIZE = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  mul_radix4_sequencer_if #(.SIZE(SIZE)) bus ();

  mul_radix4_sequencer #(.SIZE(SIZE)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p & 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic int ref_lat(input logic [SIZE-1:0] b);
`ifdef MUL_EARLY_TERM_EN
    int msb;
    msb = -1;
    for (int i = 0; i < SIZE; i++) if (b[i]) msb = i;
    if (msb < 0) return 2;
    return (msb + 2) / 2 + 1;
`else
    return SIZE / 2 + 1;
`endif
  endfunction

  // One start pulse; operands are scrambled after the start edge.
  task automatic do_mul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    int cyc;
    int busy_cnt;
    bit got;
    logic [63:0] exp_p;
    exp_p = ref_prod(a, b);
    @(negedge clk);
    bus.iStart = 1'b1;
    bus.iA = a;
    bus.iB = b;
    @(posedge clk);
    #1;
    bus.iStart = 1'b0;
    bus.iA = SIZE'($urandom);
    bus.iB = SIZE'($urandom);
    cyc = 0;
    busy_cnt = 0;
    got = 1'b0;
    while (cyc < 40 && !got) begin
      @(negedge clk);
      cyc++;
      if (bus.oBusy) busy_cnt++;
      if (bus.oDone) got = 1'b1;
    end
    check("done_seen", 64'(got), 64'd1);
    check("latency", 64'(cyc), 64'(ref_lat(b)));
    check("busy_cycles", 64'(busy_cnt), 64'(ref_lat(b)));
    check("result", 64'(bus.oResult), exp_p);
    @(negedge clk);
    check("done_pulse_ends", 64'(bus.oDone), 64'd0);
    check("idle_after_done", 64'(bus.oBusy), 64'd0);
    check("result_held", 64'(bus.oResult), exp_p);
    $display("op a=%04h b=%04h result=%08h latency=%0d", a, b, bus.oResult, cyc);
  endtask

  // iStart held high: second product starts right after the first DONE.
  task automatic do_back_to_back(input logic [SIZE-1:0] a1, input logic [SIZE-1:0] b1,
                                 input logic [SIZE-1:0] a2, input logic [SIZE-1:0] b2);
    int cyc;
    int t1;
    int t2;
    logic [63:0] r1;
    logic [63:0] r2;
    @(negedge clk);
    bus.iStart = 1'b1;
    bus.iA = a1;
    bus.iB = b1;
    @(posedge clk);
    #1;
    bus.iA = a2;
    bus.iB = b2;
    cyc = 0;
    t1 = -1;
    t2 = -1;
    r1 = '0;
    r2 = '0;
    while (cyc < 60 && t2 < 0) begin
      @(negedge clk);
      cyc++;
      if (bus.oDone) begin
        if (t1 < 0) begin
          t1 = cyc;
          r1 = 64'(bus.oResult);
        end else begin
          t2 = cyc;
          r2 = 64'(bus.oResult);
          bus.iStart = 1'b0;
        end
      end
    end
    bus.iStart = 1'b0;
    check("b2b_first_latency", 64'(t1), 64'(ref_lat(b1)));
    check("b2b_first_result", r1, ref_prod(a1, b1));
    check("b2b_gap", 64'(t2 - t1), 64'(ref_lat(b2) + 1));
    check("b2b_second_result", r2, ref_prod(a2, b2));
    $display("b2b a1=%04h b1=%04h r1=%08h t1=%0d a2=%04h b2=%04h r2=%08h t2=%0d",
             a1, b1, r1, t1, a2, b2, r2, t2);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset_abort(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    int dones;
    int busies;
    @(negedge clk);
    bus.iStart = 1'b1;
    bus.iA = a;
    bus.iB = b;
    @(posedge clk);
    #1;
    bus.iStart = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.oBusy), 64'd0);
    check("abort_done", 64'(bus.oDone), 64'd0);
    check("abort_result", 64'(bus.oResult), 64'd0);
    rst = 1'b0;
    dones = 0;
    busies = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.oDone) dones++;
      if (bus.oBusy) busies++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    check("abort_stays_idle", 64'(busies), 64'd0);
    $display("abort a=%04h b=%04h dones_after=%0d", a, b, dones);
  endtask

  initial begin
    logic [31:0] r;
    logic [SIZE-1:0] ra;
    logic [SIZE-1:0] rb;
    bus.iStart = 1'b0;
    bus.iA = '0;
    bus.iB = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.oBusy), 64'd0);
    check("reset_done", 64'(bus.oDone), 64'd0);
    check("reset_result", 64'(bus.oResult), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_mul(16'd3, 16'd5);
    do_mul(16'h1234, 16'h0003);
    do_mul(16'hFFFF, 16'hFFFF);
    do_mul(16'hABCD, 16'h0001);
    do_mul(16'hABCD, 16'h0000);
    do_mul(16'h8001, 16'h8000);

    do_back_to_back(16'h00FF, 16'h0F0F, 16'h7531, 16'h0002);

    for (int i = 0; i < 20; i++) begin
      r  = $urandom;
      ra = SIZE'(r);
      r  = $urandom;
      rb = SIZE'(r >> $urandom_range(0, 16));
      do_mul(ra, rb);
    end

    do_reset_abort(16'h4321, 16'hFEDC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_radix4_sequencer.md
# mul_radix4_sequencer

Sequential radix-4 multiplier controller that drives one shared digit-multiple datapath over SIZE/2 cycles. Each cycle it forms one partial product from a 2-bit digit of B and accumulates it into a 2*SIZE product. Requesters hand it operands with a start pulse and collect the product on a one-cycle done strobe. It replaces the fully unrolled combinational adder chain where area matters more than latency.

## Interface
- SIZE, 16, operand width; must be even and at least 4
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- iStart  in  1  request; sampled only in IDLE
- iA  in  SIZE  multiplicand, unsigned
- iB  in  SIZE  multiplier, unsigned
- oBusy  out  1  high in RUN and DONE
- oDone  out  1  one-cycle strobe; oResult is valid from this cycle
- oResult  out  2*SIZE  last completed product; held until the next completion

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE, oBusy=0, oDone=0, oResult=0; internal registers cleared.
- IDLE:
  - iStart=1 loads rA={SIZE'b0,iA}, rB=iB, rAcc=0, rStep=0, then goes to RUN.
  - iStart=0 keeps the block in IDLE.
- RUN, every cycle:
  - Digit d=rB[1:0]; multiple M = 0, rA, rA<<1 or (rA<<1)+rA for d=0..3.
  - Updates: rAcc += M; rA <<= 2; rB >>= 2; rStep += 1.
  - Goes to DONE when rStep==SIZE/2-1, i.e. after the last step executes.
- DONE: loads oResult with the final rAcc, pulses oDone, returns to IDLE.
- Arithmetic:
  - All sums are truncated to 2*SIZE bits. This is exact because the product fits in 2*SIZE bits.
  - 3*rA overflow beyond bit 2*SIZE-1 is discarded.
- iStart during RUN or DONE is ignored and not queued. iA and iB are don't-care outside the IDLE start cycle.
- Reset mid-operation aborts the operation: no oDone, and oResult returns to 0.
- The next start is accepted on the cycle after DONE, with no bubble beyond the IDLE cycle.

## Timing
- Cycle 0: iStart sampled high in IDLE.
- Cycles 1..SIZE/2: RUN, one digit per cycle.
- Cycle SIZE/2+1: DONE, with oDone=1 and oResult valid. This is 9 cycles for SIZE=16.
- oBusy is high from cycle 1 through cycle SIZE/2+1 inclusive.
- oResult is registered with no combinational path from inputs. It is stable between completions.
- Throughput: one product per SIZE/2+2 cycles.

## Configuration
- MUL_EARLY_TERM_EN defined:
  - RUN also exits to DONE when the post-shift rB is zero.
  - Latency becomes ceil((msb_index(iB)+1)/2)+1 cycles from start to oDone.
  - iB=0 still takes one RUN cycle, so oDone arrives at cycle 2.
- MUL_EARLY_TERM_EN undefined: latency is fixed at SIZE/2+1 for all operands.
- The product value is identical in both builds.

## Structure
- Shared package mul_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the step-counter width constant STEP_W = $clog2(SIZE/2);
  - the digit encodings.
- Sub-module mul_digit_mux is combinational: 2-bit digit × 2*SIZE operand → 2*SIZE multiple. Digit 3 is computed as (A<<1)+A, with explicit precedence.
- Top level holds the FSM, rA, rB, rAcc, rStep and oResult.

## Test plan
- SIZE=16, iA=3, iB=5, one start → oDone at cycle 9 (fixed build), oResult=0x0000000F.
- iA=0x1234, iB=0x0003 → oResult=0x0000369C; checks that the digit-3 multiple equals 3A, not A<<(1+A).
- iA=0xFFFF, iB=0xFFFF → oResult=0xFFFE0001; oBusy high for exactly 9 cycles.
- iStart held high throughout → products complete back-to-back every 10 cycles. A second start while busy changes neither operands nor latency.
- Reset asserted at RUN cycle 4 → next cycle IDLE with oBusy=0, oDone=0, oResult=0. No oDone follows.
- MUL_EARLY_TERM_EN with iA=0xABCD:
  - iB=0x0001 → oDone at cycle 2, oResult=0x0000ABCD.
  - iB=0 → oDone at cycle 2, oResult=0.
  - Same stimulus without the macro → oDone at cycle 9 with the same results.
